// File: rtl/irq_dispatch_n.sv
// irq_dispatch_n: breakpoint comparators with pending latches, a keyboard
// scancode FIFO, and a two-state dispatcher that presents one interrupt at a
// time and holds it until the core acknowledges.
module irq_dispatch_n #(
   parameter int NUM_BP    = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 16,
   parameter int KEY_W     = 9,
   parameter int KEY_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           addr,
   input  logic                        re,
   input  logic                        we,
   input  logic [NUM_BP*ADDR_W-1:0]    bpAddr,
   input  logic [NUM_BP-1:0]           bpEn,
   input  logic [ADDR_W-1:0]           bpVector,
   input  logic [ADDR_W-1:0]           keyboardAddr,
   input  logic                        keyEn,
   input  logic                        keyValid,
   input  logic [KEY_W-1:0]            keyCode,
   input  logic                        irqAck,
   input  logic                        overflowClr,
   output logic                        irq,
   output logic [ADDR_W-1:0]           intAddr,
   output logic [DATA_W-1:0]           intData,
   output logic [NUM_BP-1:0]           pendingBp,
   output logic [$clog2(KEY_DEPTH):0]  keyCount,
   output logic                        keyOverflow
);

   localparam int PTR_W = $clog2(KEY_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t              state_q, state_d;
   logic [NUM_BP-1:0]   hit, cand, sel_oh;
   logic [NUM_BP-1:0]   pend_q, pend_d;
   logic [DATA_W-1:0]   bp_idx;
   logic                dispatch_bp, pop_key;

   logic [KEY_W-1:0]    key_mem [KEY_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                ovf_q;
   logic                key_req, fifo_full, fifo_empty, push, drop;

   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;

   // Per-channel address comparators and pending latches. A pending bit is
   // dropped as soon as its channel is disabled, and the dispatched channel
   // also absorbs any same-cycle hit on itself.
   for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_bp
      assign hit[gi]    = (addr == bpAddr[gi*ADDR_W +: ADDR_W]) & bpEn[gi] & (re | we);
      assign pend_d[gi] = bpEn[gi] & cand[gi] & ~(dispatch_bp & sel_oh[gi]);
   end

   assign cand   = pend_q | hit;
   assign sel_oh = cand & (~cand + NUM_BP'(1));   // isolate the lowest set bit

   // Binary index of the lowest candidate channel, used as the payload.
   always_comb begin
      bp_idx = '0;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (cand[i]) bp_idx = DATA_W'(i);
      end
   end

   assign key_req    = keyValid & keyEn;
   assign fifo_full  = (cnt_q == CNT_W'(KEY_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   // A full FIFO still accepts a key when the head leaves on the same edge.
   assign push       = key_req & (~fifo_full | pop_key);
   assign drop       = key_req & fifo_full & ~pop_key;

   // Dispatcher next state: breakpoints outrank keys, no preemption in BUSY.
   always_comb begin
      state_d     = state_q;
      dispatch_bp = 1'b0;
      pop_key     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|cand) begin
               dispatch_bp = 1'b1;
               state_d     = S_BUSY;
            end else if (keyEn && !fifo_empty) begin
               pop_key = 1'b1;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (irqAck) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Scancode storage; no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) key_mem[wr_ptr_q] <= keyCode;
   end

   // State, pending bits, FIFO bookkeeping and the held interrupt payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pend_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         if (push)    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_key) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop_key})
            2'b10:   cnt_q <= cnt_q + CNT_W'(1);
            2'b01:   cnt_q <= cnt_q - CNT_W'(1);
            default: cnt_q <= cnt_q;
         endcase
         if (drop)             ovf_q <= 1'b1;
         else if (overflowClr) ovf_q <= 1'b0;
         if (dispatch_bp) begin
            addr_q <= bpVector;
            data_q <= bp_idx;
         end else if (pop_key) begin
            addr_q <= keyboardAddr;
            data_q <= DATA_W'(key_mem[rd_ptr_q]);
         end
      end
   end

   assign irq         = (state_q == S_BUSY);
   assign intAddr     = addr_q;
   assign intData     = data_q;
   assign pendingBp   = pend_q;
   assign keyCount    = cnt_q;
   assign keyOverflow = ovf_q;

endmodule

// File: tb/tb_irq_dispatch_n.sv
// Randomised bench for irq_dispatch_n: a behavioural model predicts every
// dispatch into a scoreboard queue; a negedge monitor pops and compares on
// each new interrupt and also checks the status outputs every cycle.
module tb_irq_dispatch_n;

   localparam int NUM_BP    = 4;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 16;
   localparam int KEY_W     = 9;
   localparam int KEY_DEPTH = 8;
   localparam int CNT_W     = $clog2(KEY_DEPTH) + 1;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [ADDR_W-1:0]        addr;
   logic                     re, we;
   logic [NUM_BP*ADDR_W-1:0] bpAddr;
   logic [NUM_BP-1:0]        bpEn;
   logic [ADDR_W-1:0]        bpVector, keyboardAddr;
   logic                     keyEn, keyValid;
   logic [KEY_W-1:0]         keyCode;
   logic                     irqAck, overflowClr;
   logic                     irq;
   logic [ADDR_W-1:0]        intAddr;
   logic [DATA_W-1:0]        intData;
   logic [NUM_BP-1:0]        pendingBp;
   logic [CNT_W-1:0]         keyCount;
   logic                     keyOverflow;

   always #5 clk = ~clk;

   irq_dispatch_n #(
      .NUM_BP(NUM_BP), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
      .KEY_W(KEY_W), .KEY_DEPTH(KEY_DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .addr(addr), .re(re), .we(we),
      .bpAddr(bpAddr), .bpEn(bpEn), .bpVector(bpVector),
      .keyboardAddr(keyboardAddr), .keyEn(keyEn), .keyValid(keyValid),
      .keyCode(keyCode), .irqAck(irqAck), .overflowClr(overflowClr),
      .irq(irq), .intAddr(intAddr), .intData(intData),
      .pendingBp(pendingBp), .keyCount(keyCount), .keyOverflow(keyOverflow)
   );

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } txn_t;

   // Reference model state (post-edge view of the block).
   bit                m_busy;
   bit [NUM_BP-1:0]   m_pend;
   int unsigned       m_keys[$];
   bit                m_ovf;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_data;
   txn_t              sb[$];

   bit started = 1'b0;
   bit done    = 1'b0;
   int n_vec   = 0;
   int n_err   = 0;
   int n_disp  = 0;
   logic irq_prev = 1'b0;

   // Advance the model by one clock edge using the inputs held across it.
   task automatic model_step();
      bit [NUM_BP-1:0] hit;
      int   sel;
      bit   popped;
      bit   drop;
      txn_t t;
      if (rst) begin
         m_busy = 1'b0; m_pend = '0; m_keys.delete(); m_ovf = 1'b0;
         m_addr = '0;   m_data = '0;
         return;
      end
      hit = '0;
      for (int i = 0; i < NUM_BP; i++)
         if ((re || we) && bpEn[i] && addr == bpAddr[i*ADDR_W +: ADDR_W]) hit[i] = 1'b1;
      sel = -1;
      popped = 1'b0;
      if (!m_busy) begin
         for (int i = NUM_BP - 1; i >= 0; i--)
            if (m_pend[i] || hit[i]) sel = i;
         if (sel >= 0) begin
            m_addr = bpVector;
            m_data = DATA_W'(sel);
            m_busy = 1'b1;
         end else if (keyEn && m_keys.size() > 0) begin
            m_addr = keyboardAddr;
            m_data = DATA_W'(m_keys.pop_front());
            m_busy = 1'b1;
            popped = 1'b1;
         end
         if (m_busy) begin
            t.a = m_addr; t.d = m_data;
            sb.push_back(t);
         end
      end else if (irqAck) begin
         m_busy = 1'b0;
      end
      for (int i = 0; i < NUM_BP; i++)
         m_pend[i] = bpEn[i] && (m_pend[i] || hit[i]) && (i != sel);
      drop = 1'b0;
      if (keyValid && keyEn) begin
         if (m_keys.size() < KEY_DEPTH) m_keys.push_back(int'(keyCode));
         else drop = 1'b1;
      end
      if (drop)             m_ovf = 1'b1;
      else if (overflowClr) m_ovf = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every negedge compare status; on each new irq pop the scoreboard.
   always @(negedge clk) begin
      txn_t t;
      if (started) begin
         chk("irq",         64'(irq),         64'(m_busy));
         chk("keyCount",    64'(keyCount),    64'(m_keys.size()));
         chk("pendingBp",   64'(pendingBp),   64'(m_pend));
         chk("keyOverflow", 64'(keyOverflow), 64'(m_ovf));
         chk("intAddr",     64'(intAddr),     64'(m_addr));
         chk("intData",     64'(intData),     64'(m_data));
         if (irq === 1'b1 && irq_prev !== 1'b1) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_dispatch: got addr=%h data=%h, expected none", intAddr, intData);
            end else begin
               t = sb.pop_front();
               n_disp++;
               $display("dispatch %0d: addr=%h data=%h (expected addr=%h data=%h)",
                        n_disp, intAddr, intData, t.a, t.d);
               chk("disp_addr", 64'(intAddr), 64'(t.a));
               chk("disp_data", 64'(intData), 64'(t.d));
            end
         end
         if (done) begin
            chk("scoreboard_drained", 64'(sb.size()), 64'(0));
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $finish;
         end
      end
      irq_prev = irq;
   end

   task automatic set_bp(input bit collide);
      for (int i = 0; i < NUM_BP; i++) bpAddr[i*ADDR_W +: ADDR_W] = ADDR_W'(32'h100 * (i + 1));
      // Channels 1 and 3 share an address so both hit in the same cycle.
      if (collide) bpAddr[3*ADDR_W +: ADDR_W] = 32'h200;
   endtask

   initial begin
      int k;
      rst = 1'b1; addr = '0; re = 1'b0; we = 1'b0; bpEn = '0;
      bpVector = 32'hBEEF_0000; keyboardAddr = 32'hCAFE_0000;
      keyEn = 1'b0; keyValid = 1'b0; keyCode = '0; irqAck = 1'b0; overflowClr = 1'b0;
      set_bp(1'b0);
      @(posedge clk); #1;
      model_step();
      started = 1'b1;
      bpEn = '1;
      for (int ph = 0; ph < 6; ph++) begin
         set_bp(ph == 1 || ph == 5);
         for (int c = 0; c < 300; c++) begin
            rst = (ph >= 4) && ($urandom_range(0, 49) == 0);
            re  = ($urandom_range(0, 3) == 0);
            we  = ($urandom_range(0, 3) == 0);
            k   = int'($urandom_range(0, 5));
            addr = (k < 4) ? ADDR_W'(32'h100 * (k + 1)) : ADDR_W'($urandom());
            if ($urandom_range(0, 19) == 0)
               bpEn = (ph == 0 || ph == 2) ? '1 : NUM_BP'($urandom());
            keyEn       = (ph == 3 || ph == 5) ? ($urandom_range(0, 3) != 0) : 1'b1;
            keyValid    = ($urandom_range(0, 99) < ((ph == 2) ? 50 : 20));
            keyCode     = KEY_W'($urandom());
            irqAck      = ($urandom_range(0, 99) < ((ph == 2) ? 3 : 30));
            overflowClr = ($urandom_range(0, 99) < 5);
            @(posedge clk); #1;
            model_step();
         end
      end
      done = 1'b1;
      repeat (5) @(posedge clk);
      $display("FAIL monitor_timeout: monitor did not finish, expected summary within 5 cycles");
      $fatal(1, "bench did not terminate");
   end

endmodule
